// File: rtl/rob_commit.sv
// In-order retirement buffer feeding the register-file writeback port.
// Results complete out of order; the head retires with a one-cycle write pulse then a low gap.
module rob_commit #(
    parameter int DEPTH = 8,
    parameter int TAG_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [4:0]       alloc_rd,
    input  logic [2:0]       alloc_type,
    input  logic             alloc_has_dest,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_data,
    output logic             rob_write_enable,
    output logic [31:0]      rob_write_data,
    output logic [4:0]       rob_write_index,
    output logic [2:0]       rob_write_type,
    output logic [TAG_W:0]   count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [TAG_W:0]   FULL_CNT = DEPTH[TAG_W:0];
    localparam logic [TAG_W-1:0] PTR_ONE  = {{(TAG_W-1){1'b0}}, 1'b1};

    logic [DEPTH-1:0] valid_r;
    logic [DEPTH-1:0] done_r;
    logic [DEPTH-1:0] has_dest_r;
    logic [4:0]       rd_r   [DEPTH];
    logic [2:0]       type_r [DEPTH];
    logic [31:0]      data_r [DEPTH];

    logic [TAG_W-1:0] head_r;
    logic [TAG_W-1:0] tail_r;
    logic [TAG_W:0]   count_r;
    state_t           state_r;
    logic             we_r;
    logic [31:0]      wdata_r;
    logic [4:0]       widx_r;
    logic [2:0]       wtype_r;

    state_t           state_s;
    logic             we_s;
    logic [31:0]      wdata_s;
    logic [4:0]       widx_s;
    logic [2:0]       wtype_s;
    logic             free_s;
    logic             head_ok_s;
    logic             alloc_ready_s;
    logic             alloc_fire_s;

    // Handshake terms; readiness uses the registered count so a full buffer never accepts
    always_comb begin
        alloc_ready_s = (count_r != FULL_CNT);
        alloc_fire_s  = alloc_valid && alloc_ready_s;
        head_ok_s     = valid_r[head_r] && done_r[head_r];
    end

    // Commit FSM next state and next writeback outputs
    always_comb begin
        state_s = state_r;
        we_s    = 1'b0;
        wdata_s = wdata_r;
        widx_s  = widx_r;
        wtype_s = wtype_r;
        free_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (head_ok_s) begin
                    free_s = 1'b1;
                    if (has_dest_r[head_r] && (rd_r[head_r] != 5'd0)) begin
                        we_s    = 1'b1;
                        wdata_s = data_r[head_r];
                        widx_s  = rd_r[head_r];
                        wtype_s = type_r[head_r];
                        state_s = PULSE;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            PULSE:   state_s = GAP;
            GAP:     state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state and registered writeback outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            we_r    <= 1'b0;
            wdata_r <= 32'd0;
            widx_r  <= 5'd0;
            wtype_r <= 3'd0;
        end else if (flush) begin
            state_r <= IDLE;
            we_r    <= 1'b0;
        end else begin
            state_r <= state_s;
            we_r    <= we_s;
            wdata_r <= wdata_s;
            widx_r  <= widx_s;
            wtype_r <= wtype_s;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else if (flush) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            if (alloc_fire_s) begin
                tail_r <= tail_r + PTR_ONE;
            end
            if (free_s) begin
                head_r <= head_r + PTR_ONE;
            end
            count_r <= count_r + {{TAG_W{1'b0}}, alloc_fire_s} - {{TAG_W{1'b0}}, free_s};
        end
    end

    // Entry storage: allocation at tail, completion by tag, release at head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r    <= '0;
            done_r     <= '0;
            has_dest_r <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rd_r[i]   <= 5'd0;
                type_r[i] <= 3'd0;
                data_r[i] <= 32'd0;
            end
        end else if (flush) begin
            valid_r <= '0;
            done_r  <= '0;
        end else begin
            if (alloc_fire_s) begin
                valid_r[tail_r]    <= 1'b1;
                done_r[tail_r]     <= 1'b0;
                has_dest_r[tail_r] <= alloc_has_dest;
                rd_r[tail_r]       <= alloc_rd;
                type_r[tail_r]     <= alloc_type;
            end
            // A tag that is not live is dropped, so stale completions cannot resurrect an entry
            if (cdb_valid && valid_r[cdb_tag]) begin
                data_r[cdb_tag] <= cdb_data;
                done_r[cdb_tag] <= 1'b1;
            end
            if (free_s) begin
                valid_r[head_r] <= 1'b0;
                done_r[head_r]  <= 1'b0;
            end
        end
    end

    assign alloc_ready      = alloc_ready_s;
    assign alloc_tag        = tail_r;
    assign count            = count_r;
    assign rob_write_enable = we_r;
    assign rob_write_data   = wdata_r;
    assign rob_write_index  = widx_r;
    assign rob_write_type   = wtype_r;

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit: a cycle table for retire ordering and pulse spacing,
// plus hand sequences for full buffer, flush during a pulse and asynchronous reset.
module tb_rob_commit;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        alloc_valid;
    logic        alloc_ready;
    logic [4:0]  alloc_rd;
    logic [2:0]  alloc_type;
    logic        alloc_has_dest;
    logic [2:0]  alloc_tag;
    logic        cdb_valid;
    logic [2:0]  cdb_tag;
    logic [31:0] cdb_data;
    logic        rob_write_enable;
    logic [31:0] rob_write_data;
    logic [4:0]  rob_write_index;
    logic [2:0]  rob_write_type;
    logic [3:0]  count;

    int total;
    int bad;

    rob_commit #(.DEPTH(8), .TAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_rd(alloc_rd),
        .alloc_type(alloc_type), .alloc_has_dest(alloc_has_dest), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .rob_write_enable(rob_write_enable), .rob_write_data(rob_write_data),
        .rob_write_index(rob_write_index), .rob_write_type(rob_write_type),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        av;
        logic [4:0]  rd;
        logic [2:0]  ty;
        logic        hd;
        logic        cv;
        logic [2:0]  ct;
        logic [31:0] cd;
        logic        ewe;
        logic [4:0]  eidx;
        logic [2:0]  ety;
        logic [31:0] edat;
        logic [3:0]  ecnt;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic av, logic [4:0] rd, logic [2:0] ty, logic hd,
                                logic cv, logic [2:0] ct, logic [31:0] cd,
                                logic ewe, logic [4:0] eidx, logic [2:0] ety,
                                logic [31:0] edat, logic [3:0] ecnt);
        vec_t v;
        v.av = av; v.rd = rd; v.ty = ty; v.hd = hd;
        v.cv = cv; v.ct = ct; v.cd = cd;
        v.ewe = ewe; v.eidx = eidx; v.ety = ety; v.edat = edat; v.ecnt = ecnt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_rd = 5'd0; alloc_type = 3'd0; alloc_has_dest = 1'b0;
        cdb_valid = 1'b0; cdb_tag = 3'd0; cdb_data = 32'd0; flush = 1'b0;
    endtask

    task automatic wait_we(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (rob_write_enable === 1'b1) seen = 1'b1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s: write enable never rose within 12 cycles", nm);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        idle_inputs();

        // Cycle table: av rd ty hd | cv ct cd | we idx ty data count (sampled after the edge)
        add(1, 5, 3'b010, 1, 0, 0, 32'h0,        0, 0, 0, 32'h0, 1);
        add(0, 0, 0, 0,      1, 0, 32'hDEADBEEF, 0, 0, 0, 32'h0, 1);
        add(0, 0, 0, 0,      0, 0, 32'h0,        1, 5, 3'b010, 32'hDEADBEEF, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 5, 3'b010, 32'hDEADBEEF, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 5, 3'b010, 32'hDEADBEEF, 0);
        add(1, 1, 3'b000, 1, 0, 0, 32'h0,        0, 5, 3'b010, 32'hDEADBEEF, 1);
        add(1, 2, 3'b001, 1, 0, 0, 32'h0,        0, 5, 3'b010, 32'hDEADBEEF, 2);
        add(1, 3, 3'b100, 1, 0, 0, 32'h0,        0, 5, 3'b010, 32'hDEADBEEF, 3);
        add(0, 0, 0, 0,      1, 3, 32'h30,       0, 5, 3'b010, 32'hDEADBEEF, 3);
        add(0, 0, 0, 0,      1, 2, 32'h20,       0, 5, 3'b010, 32'hDEADBEEF, 3);
        add(0, 0, 0, 0,      1, 1, 32'h10,       0, 5, 3'b010, 32'hDEADBEEF, 3);
        add(0, 0, 0, 0,      0, 0, 32'h0,        1, 1, 3'b000, 32'h10, 2);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 1, 3'b000, 32'h10, 2);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 1, 3'b000, 32'h10, 2);
        add(0, 0, 0, 0,      0, 0, 32'h0,        1, 2, 3'b001, 32'h20, 1);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 2, 3'b001, 32'h20, 1);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 2, 3'b001, 32'h20, 1);
        add(0, 0, 0, 0,      0, 0, 32'h0,        1, 3, 3'b100, 32'h30, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 3, 3'b100, 32'h30, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 3, 3'b100, 32'h30, 0);
        add(1, 9, 3'b000, 0, 0, 0, 32'h0,        0, 3, 3'b100, 32'h30, 1);
        add(1, 0, 3'b011, 1, 0, 0, 32'h0,        0, 3, 3'b100, 32'h30, 2);
        add(1, 7, 3'b010, 1, 0, 0, 32'h0,        0, 3, 3'b100, 32'h30, 3);
        add(0, 0, 0, 0,      1, 4, 32'h44,       0, 3, 3'b100, 32'h30, 3);
        add(0, 0, 0, 0,      1, 5, 32'h55,       0, 3, 3'b100, 32'h30, 2);
        add(0, 0, 0, 0,      1, 6, 32'h77,       0, 3, 3'b100, 32'h30, 1);
        add(0, 0, 0, 0,      0, 0, 32'h0,        1, 7, 3'b010, 32'h77, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 7, 3'b010, 32'h77, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 7, 3'b010, 32'h77, 0);
        add(0, 0, 0, 0,      1, 2, 32'hBAD,      0, 7, 3'b010, 32'h77, 0);
        add(0, 0, 0, 0,      0, 0, 32'h0,        0, 7, 3'b010, 32'h77, 0);

        #12;
        chk("reset_we", {31'd0, rob_write_enable}, 32'd0);
        chk("reset_data", rob_write_data, 32'd0);
        chk("reset_idx", {27'd0, rob_write_index}, 32'd0);
        chk("reset_type", {29'd0, rob_write_type}, 32'd0);
        chk("reset_count", {28'd0, count}, 32'd0);
        chk("reset_ready", {31'd0, alloc_ready}, 32'd1);
        chk("reset_tag", {29'd0, alloc_tag}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            alloc_valid = vecs[i].av; alloc_rd = vecs[i].rd; alloc_type = vecs[i].ty;
            alloc_has_dest = vecs[i].hd;
            cdb_valid = vecs[i].cv; cdb_tag = vecs[i].ct; cdb_data = vecs[i].cd;
            step();
            chk($sformatf("vec%0d_we", i), {31'd0, rob_write_enable}, {31'd0, vecs[i].ewe});
            chk($sformatf("vec%0d_idx", i), {27'd0, rob_write_index}, {27'd0, vecs[i].eidx});
            chk($sformatf("vec%0d_type", i), {29'd0, rob_write_type}, {29'd0, vecs[i].ety});
            chk($sformatf("vec%0d_data", i), rob_write_data, vecs[i].edat);
            chk($sformatf("vec%0d_count", i), {28'd0, count}, {28'd0, vecs[i].ecnt});
        end
        idle_inputs();

        // Flush while a pulse is high: head/tail are at 7, so tags are 7,0,1,2
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(10 + i); alloc_type = 3'd0; alloc_has_dest = 1'b1;
            step();
        end
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            cdb_valid = 1'b1; cdb_tag = (i == 3) ? 3'd7 : 3'(i); cdb_data = 32'(32'h100 + i);
            step();
        end
        idle_inputs();
        wait_we("flush_pulse_seen");
        chk("flush_pulse_idx", {27'd0, rob_write_index}, 32'd10);
        chk("flush_pending_count", {28'd0, count}, 32'd3);
        flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd30; alloc_has_dest = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h999;
        step();
        idle_inputs();
        chk("flush_we_drop", {31'd0, rob_write_enable}, 32'd0);
        chk("flush_count", {28'd0, count}, 32'd0);
        chk("flush_tag", {29'd0, alloc_tag}, 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            chk($sformatf("flush_quiet%0d", i), {31'd0, rob_write_enable}, 32'd0);
        end
        chk("flush_quiet_count", {28'd0, count}, 32'd0);

        // Fill to capacity; a 9th request and a request in the freeing cycle are refused
        for (int i = 0; i < 8; i++) begin
            alloc_valid = 1'b1; alloc_rd = 5'(i + 1); alloc_type = 3'd0; alloc_has_dest = 1'b1;
            step();
        end
        chk("full_count", {28'd0, count}, 32'd8);
        chk("full_ready", {31'd0, alloc_ready}, 32'd0);
        alloc_rd = 5'd31;
        step();
        chk("full_ninth_ignored", {28'd0, count}, 32'd8);
        cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_data = 32'h1234;
        step();
        chk("full_cdb_count", {28'd0, count}, 32'd8);
        cdb_valid = 1'b0;
        step();
        chk("full_commit_we", {31'd0, rob_write_enable}, 32'd1);
        chk("full_commit_idx", {27'd0, rob_write_index}, 32'd1);
        chk("full_commit_data", rob_write_data, 32'h1234);
        chk("full_refused_count", {28'd0, count}, 32'd7);
        chk("full_ready_again", {31'd0, alloc_ready}, 32'd1);
        chk("wrap_tag", {29'd0, alloc_tag}, 32'd0);
        alloc_rd = 5'd20;
        step();
        chk("wrap_count", {28'd0, count}, 32'd8);
        idle_inputs();

        // Asynchronous reset in the middle of a pulse
        cdb_valid = 1'b1; cdb_tag = 3'd1; cdb_data = 32'h222;
        step();
        idle_inputs();
        wait_we("rst_pulse_seen");
        chk("rst_pulse_idx", {27'd0, rob_write_index}, 32'd2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst_we", {31'd0, rob_write_enable}, 32'd0);
        chk("rst_data", rob_write_data, 32'd0);
        chk("rst_idx", {27'd0, rob_write_index}, 32'd0);
        chk("rst_type", {29'd0, rob_write_type}, 32'd0);
        chk("rst_count", {28'd0, count}, 32'd0);
        #2;
        rst_n = 1'b1;
        cdb_valid = 1'b1; cdb_tag = 3'd3; cdb_data = 32'h333;
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("stray_cdb_we%0d", i), {31'd0, rob_write_enable}, 32'd0);
        end
        chk("stray_cdb_count", {28'd0, count}, 32'd0);
        chk("stray_cdb_tag", {29'd0, alloc_tag}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rob_commit.md
Name: rob_commit

Overview:
In-order retirement buffer that drives the register-file writeback interface: write enable, data, destination index and load type. Dispatch allocates entries in program order. Completion results arrive tagged, possibly out of order. Entries retire strictly from the head, and each register write is a single-cycle enable pulse followed by a mandatory low cycle, because the register file captures on the rising edge of the enable.

Parameters:
DEPTH, 8, number of buffer entries (power of two)
TAG_W, 3, log2(DEPTH), width of entry tag and pointers

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all entries and pending writes
alloc_valid  in  1  dispatch requests an entry
alloc_ready  out  1  buffer can accept (count != DEPTH)
alloc_rd  in  5  destination register index
alloc_type  in  3  load subtype for writeback (LB/LH/LW/LBU/LHU codes, other = full word)
alloc_has_dest  in  1  entry writes a register (0 for store/branch)
alloc_tag  out  TAG_W  tag assigned this cycle (= tail pointer, combinational)
cdb_valid  in  1  completion result valid
cdb_tag  in  TAG_W  completing entry
cdb_data  in  32  result value
rob_write_enable  out  1  register write pulse
rob_write_data  out  32  write data (unextended; the register file applies the load extension)
rob_write_index  out  5  destination register
rob_write_type  out  3  copy of entry alloc_type
count  out  TAG_W+1  occupied entries

Behaviour:
- Reset (rst_n low, async): head=tail=count=0, all valid/done bits 0, rob_write_enable=0, rob_write_data=0, rob_write_index=0, rob_write_type=0, state=IDLE.
- Allocation: alloc_valid && alloc_ready at posedge writes {rd,type,has_dest} at tail, sets valid=1 and done=0, and tail advances mod DEPTH.
  - alloc_ready is computed from the registered count, so a full buffer refuses allocation even in a cycle where commit frees an entry.
- Completion: cdb_valid at posedge with valid[cdb_tag]=1 stores cdb_data and sets done.
  - Completion to an invalid entry is ignored.
  - Repeated completion overwrites the data.
- Commit FSM, states IDLE, PULSE, GAP, all outputs registered:
  - IDLE, head entry valid && done, has_dest=1 and rd!=0: load the write outputs from the entry, set enable=1, free the head (valid=0, head+1), go to PULSE.
  - IDLE, head entry valid && done, has_dest=0 or rd==0: free the head silently, no pulse, stay in IDLE. Retire rate is 1 per cycle.
  - PULSE: enable=0 and go to GAP. Data, index and type stay held.
  - GAP: enable stays 0, return to IDLE. Minimum spacing between rising edges of the enable is 3 cycles.
  - Data, index and type hold their last values while the enable is low.
- Done bits are sampled from registered state. A completion at edge N makes the entry commit-eligible at edge N+1 at the earliest, and the enable is high in the cycle after that edge.
- count: +1 on allocation, −1 on free, unchanged when both occur. Wrap-around of head and tail is mod DEPTH.
- Flush (synchronous, highest priority):
  - Clears valid/done, head=tail=count=0, enable=0, state=IDLE.
  - Allocation and completion in the flush cycle are discarded.
  - A pulse already high drops the next cycle, and nothing is re-issued.
- Reset mid-pulse forces the enable low immediately.
- Empty: no commit activity, enable stays 0.

Test Plan:
1. Reset, allocate rd=5 type=010 has_dest=1 (tag 0), complete tag0 data=0xDEADBEEF -> exactly one cycle with enable=1, index=5, type=010, data=0xDEADBEEF; count returns to 0.
2. Allocate tags 0..2 (rd=1,2,3), complete in order 2,1,0 with data 0x30,0x20,0x10 -> three pulses in order rd1/0x10, rd2/0x20, rd3/0x30, rising edges exactly 3 cycles apart, enable low between pulses.
3. Allocate 8 entries -> alloc_ready=0 and count=8; a 9th alloc_valid is ignored. Retire the head, then allocate -> new tag=0 (wrap).
4. Entries with has_dest=0 (tag0) and rd=0 (tag1) followed by rd=7 (tag2), all complete -> tag0 and tag1 retire in consecutive cycles with no pulse, then one pulse for rd=7.
5. Assert flush in the cycle the enable is high with 3 entries pending -> enable low next cycle, count=0, no further pulses; the next allocation gets tag 0.
6. Pull rst_n low asynchronously mid-PULSE -> enable and all outputs 0 before the next clock edge. cdb_valid to an unallocated tag -> no state change, no pulse.
